// File: rtl/ad_sampler.sv
// ad_sampler: ADC front-end driver. Divides clk to adc_clk, captures din
// at a programmable phase, optionally boxcar-averages 2^AVG_LOG2 captures.
//   clk, rst    : system clock, async active-high reset
//   en          : run enable (0 = idle, counters held at 0)
//   din         : ADC parallel data
//   adc_clk     : conversion clock to the ADC (period DIV, 50% duty)
//   dout        : averaged sample
//   dout_valid  : dout holds an unconsumed result
//   dout_ready  : downstream accepts dout when valid && ready
//   overrun     : sticky, a result was dropped; ovr_clr clears it
module ad_sampler #(
  parameter int DW        = 8,
  parameter int DIV       = 16,
  parameter int CAP_PHASE = 10,
  parameter int AVG_LOG2  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic          adc_clk,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          overrun,
  input  logic          ovr_clr
);

  localparam int CW = $clog2(DIV);
  localparam int AW = DW + AVG_LOG2;
  localparam int NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [CW-1:0] LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] RISE  = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CAP   = CW'(CAP_PHASE);
  localparam logic [NW-1:0] NLAST = NW'((1 << AVG_LOG2) - 1);

  generate
    if ((DIV % 2) != 0 || DIV < 4 ||
        CAP_PHASE < 0 || CAP_PHASE >= DIV) begin : g_bad_cfg
      $error("ad_sampler: illegal DIV/CAP_PHASE");
    end
  endgenerate

  logic [CW-1:0] cnt;
  logic [AW-1:0] acc;
  logic [NW-1:0] avg_cnt;
  logic [AW-1:0] sum;
  logic [DW-1:0] res;
  logic          capture;
  logic          last;
  logic          result;

  always_comb begin
    capture = en && (cnt == CAP);
    last    = (avg_cnt == NLAST);
    result  = capture && last;
    // acc+din cannot overflow AW: 2^AVG_LOG2 samples of DW bits
    sum     = acc + AW'(din);
    res     = DW'(sum >> AVG_LOG2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      adc_clk <= 1'b0;
    end else if (!en) begin
      cnt     <= '0;
      adc_clk <= 1'b0;
    end else begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      if (cnt == RISE)
        adc_clk <= 1'b1;
      else if (cnt == LAST)
        adc_clk <= 1'b0;
    end
  end

  // a partial average is discarded whenever en drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      avg_cnt <= '0;
    end else if (!en) begin
      acc     <= '0;
      avg_cnt <= '0;
    end else if (capture) begin
      if (last) begin
        acc     <= '0;
        avg_cnt <= '0;
      end else begin
        acc     <= sum;
        avg_cnt <= avg_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (result) begin
      if (!dout_valid || dout_ready) begin
        dout       <= res;
        dout_valid <= 1'b1;
      end
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  // a drop wins over a coincident clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overrun <= 1'b0;
    else if (result && dout_valid && !dout_ready)
      overrun <= 1'b1;
    else if (ovr_clr)
      overrun <= 1'b0;
  end

endmodule

// File: tb/tb_ad_sampler.sv
// tb_ad_sampler: randomized bench for ad_sampler, two instances
// (no averaging and 4-sample averaging) against a behavioural model.
module tb_ad_sampler;

  localparam int DIV = 16;
  localparam int CAP = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] din;
  logic       dout_ready;
  logic       ovr_clr;

  logic       adc [2];
  logic       dv  [2];
  logic       ov  [2];
  logic [7:0] dq  [2];

  int vec  = 0;
  int errs = 0;
  int cyc  = 0;

  always #5 clk = ~clk;

  ad_sampler #(.DW(8), .DIV(DIV), .CAP_PHASE(CAP), .AVG_LOG2(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .adc_clk(adc[0]), .dout(dq[0]), .dout_valid(dv[0]),
    .dout_ready(dout_ready), .overrun(ov[0]), .ovr_clr(ovr_clr)
  );

  ad_sampler #(.DW(8), .DIV(DIV), .CAP_PHASE(CAP), .AVG_LOG2(2)) u_b (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .adc_clk(adc[1]), .dout(dq[1]), .dout_valid(dv[1]),
    .dout_ready(dout_ready), .overrun(ov[1]), .ovr_clr(ovr_clr)
  );

  // model: enabled-cycle count, running sum/count of captures,
  // and the output register rules
  int         age;
  int         msum [2];
  int         mn   [2];
  logic [7:0] m_dout [2];
  bit         m_val [2];
  bit         m_ovr [2];
  bit         m_adc;

  function automatic int navg(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic model_clear();
    age   = 0;
    m_adc = 1'b0;
    for (int k = 0; k < 2; k++) begin
      msum[k] = 0; mn[k] = 0; m_dout[k] = 8'd0;
      m_val[k] = 1'b0; m_ovr[k] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_clear();
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit res;
        int r;
        res = 1'b0;
        r   = 0;
        if (!en) begin
          msum[k] = 0; mn[k] = 0;
        end else if (age % DIV == CAP) begin
          msum[k] += int'(din);
          mn[k]++;
          if (mn[k] == navg(k)) begin
            res = 1'b1;
            r   = msum[k] / navg(k);
            msum[k] = 0; mn[k] = 0;
          end
        end
        if (res && m_val[k] && !dout_ready) m_ovr[k] = 1'b1;
        else if (ovr_clr) m_ovr[k] = 1'b0;
        if (res && (!m_val[k] || dout_ready)) begin
          m_dout[k] = r[7:0];
          m_val[k]  = 1'b1;
        end else if (!res && m_val[k] && dout_ready) begin
          m_val[k] = 1'b0;
        end
      end
      m_adc = en && (((age + 1) % DIV) >= DIV / 2);
      age   = en ? age + 1 : 0;
    end
    #1;
  endtask

  // advance until the next edge is a capture edge (bounded)
  task automatic to_cap(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * DIV; i++) begin
      if (en && (age % DIV == CAP)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; din = 8'd0;
    dout_ready = 1'b0; ovr_clr = 1'b0;
    model_clear();
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    for (int k = 0; k < 2; k++) begin
      vec++;
      if (adc[k] !== 1'b0) begin
        errs++; $display("FAIL idle_adc k=%0d got %b want 0", k, adc[k]);
      end
      vec++;
      if (dv[k] !== 1'b0) begin
        errs++; $display("FAIL idle_valid k=%0d got %b want 0", k, dv[k]);
      end
    end
    en = 1'b1;
    repeat (36) begin din = 8'($urandom); tick(); end
    vec++;
    if (ov[0] !== 1'b1) begin
      errs++; $display("FAIL pre_rst_ovr got %b want 1", ov[0]);
    end
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      vec++;
      if ({adc[k], dv[k], ov[k], dq[k]} !== 11'd0) begin
        errs++;
        $display("FAIL async_rst k=%0d got adc=%b v=%b o=%b d=%h want 0",
                 k, adc[k], dv[k], ov[k], dq[k]);
      end
    end
    model_clear();
    tick();
    rst = 1'b0;
    en  = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    int nv, nh;
    dout_ready = 1'b1;
    en = 1'b1;
    nv = 0; nh = 0;
    for (int i = 0; i < 16 + 128; i++) begin
      din = cyc[7:0];
      tick();
      vec++;
      if (adc[0] !== m_adc) begin
        errs++; $display("FAIL stream_adc got %b want %b", adc[0], m_adc);
      end
      vec++;
      if (dv[0] !== m_val[0]) begin
        errs++; $display("FAIL stream_valid got %b want %b", dv[0], m_val[0]);
      end
      vec++;
      if (dq[0] !== m_dout[0]) begin
        errs++; $display("FAIL stream_dout got %h want %h", dq[0], m_dout[0]);
      end
      if (i >= 16) begin
        nv += int'(dv[0]);
        nh += int'(adc[0]);
      end
    end
    vec++;
    if (nv != 8) begin
      errs++; $display("FAIL stream_pulses got %0d want 8", nv);
    end
    vec++;
    if (nh != 64) begin
      errs++; $display("FAIL stream_adc_high got %0d want 64", nh);
    end
  endtask

  task automatic test_average();
    logic [7:0] tbl [4];
    int caps, nv;
    tbl[0] = 8'd10; tbl[1] = 8'd20; tbl[2] = 8'd30; tbl[3] = 8'd41;
    en = 1'b0; tick();
    en = 1'b1; dout_ready = 1'b1;
    caps = 0;
    for (int i = 0; i < 100 && caps < 4; i++) begin
      if (age % DIV == CAP) begin
        din = tbl[caps]; caps++;
      end else begin
        din = 8'($urandom);
      end
      tick();
    end
    vec++;
    if (dv[1] !== 1'b1 || dq[1] !== 8'd25) begin
      errs++; $display("FAIL avg_25 got v=%b d=%0d want v=1 d=25", dv[1], dq[1]);
    end
    nv = 0;
    for (int i = 0; i < 128; i++) begin
      din = 8'($urandom);
      tick();
      nv += int'(dv[1]);
      vec++;
      if (dv[1] !== m_val[1] || dq[1] !== m_dout[1]) begin
        errs++;
        $display("FAIL avg_group got v=%b d=%h want v=%b d=%h",
                 dv[1], dq[1], m_val[1], m_dout[1]);
      end
    end
    vec++;
    if (nv != 2) begin
      errs++; $display("FAIL avg_rate got %0d want 2", nv);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    logic [7:0] first;
    dout_ready = 1'b1;
    repeat (20) tick();
    dout_ready = 1'b0;
    to_cap(ok);
    first = 8'($urandom);
    din = first;
    tick();
    to_cap(ok);
    din = ~first;
    tick();
    vec++;
    if (!ok || dq[0] !== first || ov[0] !== 1'b1) begin
      errs++;
      $display("FAIL ovr_hold got d=%h o=%b want d=%h o=1", dq[0], ov[0], first);
    end
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    vec++;
    if (ov[0] !== 1'b0) begin
      errs++; $display("FAIL ovr_clr got %b want 0", ov[0]);
    end
    dout_ready = 1'b1; tick();
    vec++;
    if (dv[0] !== 1'b0 || dq[0] !== first) begin
      errs++;
      $display("FAIL ovr_drain got v=%b d=%h want v=0 d=%h", dv[0], dq[0], first);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] nxt;
    dout_ready = 1'b0;
    to_cap(ok);
    din = 8'($urandom);
    tick();
    to_cap(ok);
    nxt = 8'($urandom);
    din = nxt;
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    vec++;
    if (!ok || dv[0] !== 1'b1 || dq[0] !== nxt || ov[0] !== 1'b0) begin
      errs++;
      $display("FAIL b2b got v=%b d=%h o=%b want v=1 d=%h o=0",
               dv[0], dq[0], ov[0], nxt);
    end
    to_cap(ok);
    din = ~nxt;
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    vec++;
    if (!ok || ov[0] !== 1'b1 || dq[0] !== nxt) begin
      errs++;
      $display("FAIL drop_vs_clr got o=%b d=%h want o=1 d=%h", ov[0], dq[0], nxt);
    end
    ovr_clr = 1'b1; dout_ready = 1'b1; tick();
    ovr_clr = 1'b0;
  endtask

  task automatic test_en_drop();
    bit ok;
    en = 1'b0; tick();
    en = 1'b1; din = 8'd0; dout_ready = 1'b1;
    repeat (2) begin to_cap(ok); tick(); end
    en = 1'b0;
    repeat (3) tick();
    en = 1'b1; din = 8'hFF;
    repeat (3) begin to_cap(ok); tick(); end
    vec++;
    if (dv[1] !== 1'b0) begin
      errs++; $display("FAIL en_early got v=%b want 0", dv[1]);
    end
    to_cap(ok); tick();
    vec++;
    if (!ok || dv[1] !== 1'b1 || dq[1] !== 8'hFF) begin
      errs++; $display("FAIL en_fresh got v=%b d=%h want v=1 d=ff", dv[1], dq[1]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      en         = ($urandom_range(0, 29) != 0);
      dout_ready = ($urandom_range(0, 2) != 0);
      ovr_clr    = ($urandom_range(0, 15) == 0);
      din        = 8'($urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        vec++;
        if (adc[k] !== m_adc || dv[k] !== m_val[k] ||
            dq[k] !== m_dout[k] || ov[k] !== m_ovr[k]) begin
          errs++;
          $display("FAIL rand k=%0d cyc=%0d got a=%b v=%b d=%h o=%b want a=%b v=%b d=%h o=%b",
                   k, cyc, adc[k], dv[k], dq[k], ov[k],
                   m_adc, m_val[k], m_dout[k], m_ovr[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_average();
    test_overrun();
    test_back_to_back();
    test_en_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
